// File: rtl/mux_arb_nto1.sv
// Registered N:1 word multiplexer with valid/ready on every channel and on the output.
// Round-robin arbitration is built only when MUX_ARB_RR_EN is defined; otherwise Sel directs.
module mux_arb_nto1 #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = $clog2(CHANNELS)
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic [CHANNELS*WIDTH-1:0]  Din,
  input  logic [CHANNELS-1:0]        Din_valid,
  output logic [CHANNELS-1:0]        Din_ready,
  input  logic [SEL_W-1:0]           Sel,
  input  logic                       Mode,
  output logic signed [WIDTH-1:0]    Dout,
  output logic                       Dout_valid,
  input  logic                       Dout_ready,
  output logic [SEL_W-1:0]           Dout_chan
);

  logic [WIDTH-1:0] dout_q;
  logic             dout_valid_q;
  logic [SEL_W-1:0] dout_chan_q;

  logic             can_load;
  logic             grant;
  logic [SEL_W-1:0] g;
  logic             load_en;
  logic             use_rr;

  logic             dir_grant;
  assign dir_grant = (32'(Sel) < CHANNELS) && Din_valid[Sel];

`ifdef MUX_ARB_RR_EN
  logic [SEL_W-1:0] ptr_q;
  logic             rr_grant;
  logic [SEL_W-1:0] rr_g;

  // First valid channel strictly after ptr_q, wrapping modulo CHANNELS.
  always_comb begin
    rr_grant = 1'b0;
    rr_g     = '0;
    for (int unsigned off = 1; off <= CHANNELS; off++) begin
      logic [SEL_W-1:0] cand;
      cand = SEL_W'((32'(ptr_q) + off) % CHANNELS);
      if (!rr_grant && Din_valid[cand]) begin
        rr_grant = 1'b1;
        rr_g     = cand;
      end
    end
  end

  assign use_rr = Mode;
`else
  logic unused_mode;
  assign unused_mode = Mode;
  assign use_rr      = 1'b0;
`endif

  always_comb begin
    grant = dir_grant;
    g     = Sel;
`ifdef MUX_ARB_RR_EN
    if (use_rr) begin
      grant = rr_grant;
      g     = rr_g;
    end
`endif
  end

  assign can_load = !dout_valid_q || Dout_ready;
  assign load_en  = can_load && grant;

  always_comb begin
    Din_ready = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      Din_ready[i] = load_en && (g == SEL_W'(i));
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_chan_q  <= '0;
    end else if (load_en) begin
      dout_q       <= Din[32'(g)*WIDTH +: WIDTH];
      dout_valid_q <= 1'b1;
      dout_chan_q  <= g;
    end else if (dout_valid_q && Dout_ready) begin
      dout_valid_q <= 1'b0;
    end
  end

`ifdef MUX_ARB_RR_EN
  // Reset to the last channel so channel 0 wins the first search.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ptr_q <= SEL_W'(CHANNELS - 1);
    end else if (load_en && use_rr) begin
      ptr_q <= g;
    end
  end
`endif

  assign Dout       = dout_q;
  assign Dout_valid = dout_valid_q;
  assign Dout_chan  = dout_chan_q;

endmodule

// File: tb/tb_mux_arb_nto1.sv
// Directed bench for mux_arb_nto1: a 4-channel and a 3-channel instance share clock and reset.
// Round-robin steps are included when MUX_ARB_RR_EN is defined.
module tb_mux_arb_nto1;

  logic        Clk;
  logic        Reset_n;

  logic [31:0] d4 [4];
  logic [127:0] din4;
  logic [3:0]  din_valid4;
  logic [3:0]  din_ready4;
  logic [1:0]  sel4;
  logic        mode4;
  logic [31:0] dout4;
  logic        dout_valid4;
  logic        dout_ready4;
  logic [1:0]  dout_chan4;

  logic [31:0] d3 [3];
  logic [95:0] din3;
  logic [2:0]  din_valid3;
  logic [2:0]  din_ready3;
  logic [1:0]  sel3;
  logic [31:0] dout3;
  logic        dout_valid3;
  logic        dout_ready3;
  logic [1:0]  dout_chan3;

  int n_cmp = 0;
  int n_err = 0;

  assign din4 = {d4[3], d4[2], d4[1], d4[0]};
  assign din3 = {d3[2], d3[1], d3[0]};

  mux_arb_nto1 #(.WIDTH(32), .CHANNELS(4)) u_dut4 (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .Din        (din4),
    .Din_valid  (din_valid4),
    .Din_ready  (din_ready4),
    .Sel        (sel4),
    .Mode       (mode4),
    .Dout       (dout4),
    .Dout_valid (dout_valid4),
    .Dout_ready (dout_ready4),
    .Dout_chan  (dout_chan4)
  );

  mux_arb_nto1 #(.WIDTH(32), .CHANNELS(3)) u_dut3 (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .Din        (din3),
    .Din_valid  (din_valid3),
    .Din_ready  (din_ready3),
    .Sel        (sel3),
    .Mode       (1'b0),
    .Dout       (dout3),
    .Dout_valid (dout_valid3),
    .Dout_ready (dout_ready3),
    .Dout_chan  (dout_chan3)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse_reset();
    Reset_n = 1'b0;
    #2;
    Reset_n = 1'b1;
  endtask

  initial begin
    Reset_n     = 1'b1;
    for (int i = 0; i < 4; i++) d4[i] = 32'h0;
    for (int i = 0; i < 3; i++) d3[i] = 32'h0;
    din_valid4  = 4'b0;
    sel4        = 2'd0;
    mode4       = 1'b0;
    dout_ready4 = 1'b0;
    din_valid3  = 3'b0;
    sel3        = 2'd0;
    dout_ready3 = 1'b0;
    #1 Reset_n  = 1'b0;
    #1;
    chk("rst_dout", 64'(dout4), 64'h0);
    chk("rst_valid", 64'(dout_valid4), 64'h0);
    chk("rst_chan", 64'(dout_chan4), 64'h0);
    @(negedge Clk);
    Reset_n = 1'b1;
    step();

    // Directed select of channel 2 with every channel valid.
    d4[0] = 32'h0000_0A00; d4[1] = 32'h0000_0B11;
    d4[2] = 32'hFFFF_FFF0; d4[3] = 32'h0000_0D33;
    sel4 = 2'd2; din_valid4 = 4'b1111; dout_ready4 = 1'b1;
    #1;
    chk("dir_ready", 64'(din_ready4), 64'h4);
    step();
    chk("dir_dout", 64'(dout4), 64'hFFFF_FFF0);
    chk("dir_valid", 64'(dout_valid4), 64'h1);
    chk("dir_chan", 64'(dout_chan4), 64'h2);

    // Drain with nothing valid: valid drops, data and channel stay.
    din_valid4 = 4'b0;
    step();
    chk("drain_valid", 64'(dout_valid4), 64'h0);
    chk("drain_dout", 64'(dout4), 64'hFFFF_FFF0);
    chk("drain_chan", 64'(dout_chan4), 64'h2);

    // Backpressure on channel 1.
    sel4 = 2'd1; d4[1] = 32'h1111_1111; din_valid4 = 4'b0010;
    step();
    chk("bp_load_dout", 64'(dout4), 64'h1111_1111);
    chk("bp_load_chan", 64'(dout_chan4), 64'h1);
    d4[1] = 32'h2222_2222; dout_ready4 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_hold_ready", 64'(din_ready4), 64'h0);
      step();
      chk("bp_hold_dout", 64'(dout4), 64'h1111_1111);
      chk("bp_hold_valid", 64'(dout_valid4), 64'h1);
      chk("bp_hold_chan", 64'(dout_chan4), 64'h1);
    end
    dout_ready4 = 1'b1;
    #1;
    chk("bp_release_ready", 64'(din_ready4), 64'h2);
    step();
    chk("bp_swap_dout", 64'(dout4), 64'h2222_2222);
    chk("bp_swap_valid", 64'(dout_valid4), 64'h1);
    chk("bp_swap_chan", 64'(dout_chan4), 64'h1);

    // Channel 3, bit pattern passed unchanged.
    sel4 = 2'd3; d4[3] = 32'h8000_0001; din_valid4 = 4'b1000;
    #1;
    chk("ch3_ready", 64'(din_ready4), 64'h8);
    step();
    chk("ch3_dout", 64'(dout4), 64'h8000_0001);
    chk("ch3_chan", 64'(dout_chan4), 64'h3);

    // Three-channel instance: Sel beyond the last channel never grants.
    d3[0] = 32'h0000_0C00; d3[1] = 32'h0000_0C01; d3[2] = 32'h0000_ABCD;
    din_valid3 = 3'b111; sel3 = 2'd2; dout_ready3 = 1'b1;
    step();
    chk("oor_load_dout", 64'(dout3), 64'h0000_ABCD);
    chk("oor_load_chan", 64'(dout_chan3), 64'h2);
    sel3 = 2'd3;
    #1;
    chk("oor_ready", 64'(din_ready3), 64'h0);
    step();
    chk("oor_valid", 64'(dout_valid3), 64'h0);
    chk("oor_ready_after", 64'(din_ready3), 64'h0);

    // Asynchronous reset while holding a word.
    dout_ready4 = 1'b0; din_valid4 = 4'b0010; sel4 = 2'd1;
    step();
    chk("ar_pre_valid", 64'(dout_valid4), 64'h1);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("ar_dout", 64'(dout4), 64'h0);
    chk("ar_valid", 64'(dout_valid4), 64'h0);
    chk("ar_chan", 64'(dout_chan4), 64'h0);
    Reset_n = 1'b1;
    sel4 = 2'd0; d4[0] = 32'h5A5A_5A5A; din_valid4 = 4'b0001; dout_ready4 = 1'b1;
    step();
    chk("post_rst_dout", 64'(dout4), 64'h5A5A_5A5A);
    chk("post_rst_valid", 64'(dout_valid4), 64'h1);

`ifdef MUX_ARB_RR_EN
    // Round-robin fairness from reset.
    din_valid4 = 4'b0;
    step();
    pulse_reset();
    mode4 = 1'b1; din_valid4 = 4'b1111; dout_ready4 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("rr_fair_chan", 64'(dout_chan4), 64'(k % 4));
      chk("rr_fair_dout", 64'(dout4), 64'(d4[k % 4]));
    end

    // Skip idle channels and wrap from 3 back to 0.
    din_valid4 = 4'b0;
    step();
    pulse_reset();
    din_valid4 = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rr_wrap_chan", 64'(dout_chan4), (k % 2 == 0) ? 64'h0 : 64'h3);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
